// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_arbiter_pkg;

  // Width of the owner index and round-robin pointer; covers up to 4 requesters.
  localparam int unsigned OwnerW = 2;

  // Requester index assignments.
  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_DMA = 1;
  localparam int unsigned REQ_OUT = 2;

  // Arbiter states: IDLE (no grant) and OWNED (exactly one grant bit set).
  typedef enum logic {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant bundle between bus requesters and the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3
);

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [NREQ-1:0]   grant;
  logic [OwnerW-1:0] owner;
  logic              busy;
  logic              preempt;

  // Requester side.
  modport master (
    output req,
    output lock,
    input  grant,
    input  owner,
    input  busy,
    input  preempt
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  lock,
    output grant,
    output owner,
    output busy,
    output preempt
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first masked request at or above rr_ptr, wrapping.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   mask_i,
  input  logic [OwnerW-1:0] rr_ptr_i,
  output logic [NREQ-1:0]   winner_o,
  output logic              found_o
);

  localparam logic [OwnerW:0] NReqV = (OwnerW + 1)'(NREQ);

  logic [NREQ-1:0] cand;
  logic [OwnerW:0] idx;
  logic            found;

  assign cand = req_i & mask_i;

  // Scan from rr_ptr upward; rr_ptr < NREQ so one subtraction wraps the index.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr_i} + (OwnerW + 1)'(i);
      if (idx >= NReqV) begin
        idx = idx - NReqV;
      end
      if (!found && cand[idx[OwnerW-1:0]]) begin
        winner_o[idx[OwnerW-1:0]] = 1'b1;
        found                     = 1'b1;
      end
    end
  end

  assign found_o = found;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin memory bus arbiter with hold-time preemption and owner lock.
// All outputs are flops; req/lock only reach them through the next-state logic.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset_cycle,
  mem_arbiter_if.slave bus
);

  localparam int unsigned       HoldW   = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0]  HoldMax = HoldW'(MAX_HOLD);
  localparam logic [OwnerW-1:0] LastIdx = OwnerW'(NREQ - 1);

  arb_state_e        state_q;
  logic [NREQ-1:0]   grant_q;
  logic [OwnerW-1:0] owner_q;
  logic [OwnerW-1:0] rr_ptr_q;
  logic              busy_q;
  logic              preempt_q;
  logic [HoldW-1:0]  hold_cnt_q;

  logic [NREQ-1:0]   mask;
  logic [NREQ-1:0]   winner;
  logic              found;
  logic              owner_req;
  logic              owner_lock;
  logic              hold_full;
  logic [OwnerW-1:0] win_idx;
  logic [OwnerW-1:0] next_ptr;
  logic              do_grant;
  logic              do_preempt;
  logic              do_idle;

  // Re-arbitration while owned never considers the current owner.
  assign mask       = (state_q == StOwned) ? ~grant_q : '1;
  assign owner_req  = |(bus.req & grant_q);
  assign owner_lock = |(bus.lock & grant_q);
  assign hold_full  = (hold_cnt_q == HoldMax);

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req_i    (bus.req),
    .mask_i   (mask),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  // Binary index of the one-hot winner and the pointer value that follows it.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        win_idx = OwnerW'(i);
      end
    end
    next_ptr = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
  end

  // Decide this edge's action; a release takes priority over preemption.
  always_comb begin
    do_grant   = 1'b0;
    do_preempt = 1'b0;
    do_idle    = 1'b0;
    unique case (state_q)
      StIdle: begin
        do_grant = found;
      end
      StOwned: begin
        if (!owner_req) begin
          do_grant = found;
          do_idle  = !found;
        end else if (hold_full && !owner_lock && found) begin
          do_grant   = 1'b1;
          do_preempt = 1'b1;
        end
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      preempt_q <= do_preempt;
      if (do_grant) begin
        state_q    <= StOwned;
        grant_q    <= winner;
        owner_q    <= win_idx;
        busy_q     <= 1'b1;
        rr_ptr_q   <= next_ptr;
        hold_cnt_q <= HoldW'(1);
      end else if (do_idle) begin
        state_q    <= StIdle;
        grant_q    <= '0;
        owner_q    <= '0;
        busy_q     <= 1'b0;
        hold_cnt_q <= '0;
      end else if (state_q == StOwned && !hold_full) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end

  assign bus.grant   = grant_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level model of the arbitration rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned MAX_HOLD = 8;

  typedef struct packed {
    logic [NREQ-1:0]   grant;
    logic [OwnerW-1:0] owner;
    logic              busy;
    logic              preempt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_cycle;

  mem_arbiter_if #(.NREQ(NREQ)) bus ();

  mem_arbiter #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset_cycle (reset_cycle),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int   n_vec    = 0;
  int   n_miss   = 0;
  int   pre_seen = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q[$];

  // Reference model: owner index (-1 = none), pointer, cycles held so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int excl);
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  function automatic void take(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % NREQ;
    m_held  = 1;
  endfunction

  function automatic exp_t model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    exp_t e;
    int   w;
    logic pre = 1'b0;
    if (m_owner < 0) begin
      w = pick(r, -1);
      if (w >= 0) take(w);
    end else if (!r[m_owner]) begin
      w = pick(r, m_owner);
      if (w >= 0) take(w);
      else m_owner = -1;
    end else begin
      w = pick(r, m_owner);
      if (m_held >= MAX_HOLD && !l[m_owner] && w >= 0) begin
        take(w);
        pre = 1'b1;
      end else begin
        m_held++;
      end
    end
    e = '0;
    if (m_owner >= 0) begin
      e.grant[m_owner] = 1'b1;
      e.owner          = OwnerW'(m_owner);
      e.busy           = 1'b1;
    end
    e.preempt = pre;
    return e;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue the expected outputs.
  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    @(negedge clk);
    bus.req  = r;
    bus.lock = l;
    exp_q.push_back(model_step(r, l));
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and confirm the outputs drop before any clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    mon_en      = 1'b0;
    bus.req     = '0;
    bus.lock    = '0;
    reset_cycle = 1'b1;
    #1;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_owner", 32'(bus.owner), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_preempt", 32'(bus.preempt), 32'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_cycle = 1'b0;
    mon_en      = 1'b1;
  endtask

  // Monitor: compare every registered output set against the queued expectation.
  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() != 0) begin
        e         = exp_q.pop_front();
        a.grant   = bus.grant;
        a.owner   = bus.owner;
        a.busy    = bus.busy;
        a.preempt = bus.preempt;
        if (a.preempt === 1'b1) pre_seen++;
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL scoreboard @%0t: got grant=%b owner=%0d busy=%b preempt=%b, expected grant=%b owner=%0d busy=%b preempt=%b",
                   $time, a.grant, a.owner, a.busy, a.preempt,
                   e.grant, e.owner, e.busy, e.preempt);
        end
      end
    end
  end

  initial begin : stimulus
    logic [NREQ-1:0] r = '0;
    logic [NREQ-1:0] l = '0;
    int p0;

    reset_cycle = 1'b1;
    bus.req     = '0;
    bus.lock    = '0;
    #1;
    check("init_grant", 32'(bus.grant), 32'h0);
    check("init_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_cycle = 1'b0;
    mon_en      = 1'b1;

    // Single requester: 1-cycle latency, release to idle, pointer moves past 0.
    cycle(3'b001, '0);
    settle();
    check("single_grant", 32'(bus.grant), 32'(1 << REQ_CPU));
    cycle(3'b001, '0);
    cycle(3'b001, '0);
    cycle(3'b000, '0);
    settle();
    check("single_idle", 32'(bus.busy), 32'h0);
    cycle(3'b011, '0);
    settle();
    check("single_ptr", 32'(bus.grant), 32'(1 << REQ_DMA));
    cycle(3'b000, '0);

    // All three request; each drops after two owned cycles.
    do_reset();
    cycle(3'b111, '0);
    cycle(3'b111, '0);
    cycle(3'b110, '0);
    settle();
    check("rr_second", 32'(bus.grant), 32'(1 << REQ_DMA));
    cycle(3'b110, '0);
    cycle(3'b100, '0);
    settle();
    check("rr_third", 32'(bus.grant), 32'(1 << REQ_OUT));
    check("rr_no_gap", 32'(bus.busy), 32'h1);
    cycle(3'b100, '0);
    cycle(3'b000, '0);

    // Unlocked owner preempted after MAX_HOLD cycles, later regranted.
    do_reset();
    p0 = pre_seen;
    for (int i = 0; i < MAX_HOLD; i++) cycle(3'b011, '0);
    cycle(3'b011, '0);
    settle();
    check("preempt_grant", 32'(bus.grant), 32'(1 << REQ_DMA));
    check("preempt_pulse", 32'(bus.preempt), 32'h1);
    for (int i = 0; i < 3; i++) cycle(3'b011, '0);
    cycle(3'b001, '0);
    settle();
    check("preempt_regrant", 32'(bus.grant), 32'(1 << REQ_CPU));
    check("preempt_count", 32'(pre_seen - p0), 32'h1);
    cycle(3'b000, '0);

    // Locked owner keeps the bus.
    do_reset();
    p0 = pre_seen;
    for (int i = 0; i < 24; i++) cycle(3'b011, 3'b001);
    settle();
    check("lock_grant", 32'(bus.grant), 32'(1 << REQ_CPU));
    check("lock_no_preempt", 32'(pre_seen - p0), 32'h0);
    cycle(3'b000, '0);

    // Release coinciding with hold limit counts as a release.
    do_reset();
    for (int i = 0; i < MAX_HOLD; i++) cycle(3'b011, '0);
    cycle(3'b010, '0);
    settle();
    check("coinc_grant", 32'(bus.grant), 32'(1 << REQ_DMA));
    check("coinc_preempt", 32'(bus.preempt), 32'h0);
    cycle(3'b000, '0);

    // Asynchronous reset while requester 2 owns, then restart from index 0.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(3'b100, '0);
    settle();
    check("pre_rst_grant", 32'(bus.grant), 32'(1 << REQ_OUT));
    do_reset();
    cycle(3'b111, '0);
    settle();
    check("post_rst_first", 32'(bus.grant), 32'(1 << REQ_CPU));
    cycle(3'b000, '0);

    // Random traffic with one mid-stream reset.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(9) == 0) r[i] = ~r[i];
        if ($urandom_range(15) == 0) l[i] = ~l[i];
      end
      cycle(r, l);
      if (c == 400) begin
        do_reset();
        r = '0;
        l = '0;
      end
    end
    cycle('0, '0);
    settle();
    settle();
    check("drain", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of bus requesters (CPU fetch = 0, DMA loader = 1, output refresh = 2).
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive granted cycles before an unlocked owner is preempted.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset_cycle  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester bus request, level; held high while the bus is wanted.
REQ-006 lock  input  NREQ  per-requester no-preempt flag; only the current owner's bit is significant.
REQ-007 grant  output  NREQ  one-hot or zero bus grant, registered.
REQ-008 owner  output  2  binary index of granted requester, registered; 0 when busy is low.
REQ-009 busy  output  1  high while any grant bit is high, registered.
REQ-010 preempt  output  1  one-cycle pulse on the edge an owner is forcibly removed, registered.

Function
REQ-011 The block SHALL have two states: IDLE (grant = 0) and OWNED (exactly one grant bit high).
REQ-012 In IDLE, when any req bit is sampled high at a posedge, that edge SHALL enter OWNED and grant the winner; latency from req high to grant high is 1 cycle.
REQ-013 The winner SHALL be the first requesting index at or above rr_ptr, wrapping from NREQ-1 to 0.
REQ-014 On every grant transfer, rr_ptr SHALL become winner+1 modulo NREQ.
REQ-015 In OWNED, the grant SHALL stay unchanged while the owner's req is high and no preemption applies.
REQ-016 Release: the owner's req is sampled low. Re-arbitration at that same edge SHALL exclude the owner. If another request exists, grant moves directly with no idle cycle; otherwise the block enters IDLE.
REQ-017 hold_cnt SHALL load 1 on each new grant and increment each OWNED cycle, saturating at MAX_HOLD.
REQ-018 Preemption: hold_cnt == MAX_HOLD, the owner's lock bit low and another req bit high. Grant SHALL then move to the next winner, excluding the owner, and preempt SHALL pulse for that one cycle.
REQ-019 With lock high, or no other requester, the owner SHALL keep the bus indefinitely. hold_cnt saturates and preempt stays low.
REQ-020 If release and the preemption condition coincide, the event SHALL be treated as a release with preempt low.
REQ-021 A preempted owner with req still high SHALL remain pending and be served by normal round-robin order.
REQ-022 When NREQ requesters assert simultaneously from IDLE with rr_ptr = 0, grants SHALL follow the order 0,1,2,0,… as each releases or is preempted.
REQ-023 grant, owner and busy SHALL always be mutually consistent in the same cycle.
REQ-024 req bits for indices >= NREQ do not exist; owner width SHALL suffice for NREQ <= 4.

Reset
REQ-025 reset_cycle high SHALL immediately force: state IDLE, grant 0, owner 0, busy 0, preempt 0, rr_ptr 0, hold_cnt 0.
REQ-026 Reset asserted mid-ownership SHALL drop the grant without a preempt pulse.
REQ-027 After reset deasserts, the first arbitration SHALL start from index 0.

Structure
REQ-028 The state encodings (IDLE, OWNED) and requester index constants (REQ_CPU, REQ_DMA, REQ_OUT) SHALL live in the shared parameters include file.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs req, mask and rr_ptr, and outputs a one-hot winner and a found flag.
REQ-030 All outputs SHALL come directly from flops; no combinational path from req or lock to grant.

Verification
REQ-031 Reset, then req=001 for 3 cycles, then 000 -> grant=001 one cycle after req; busy high 3 cycles; IDLE after release; rr_ptr=1.
REQ-032 After reset, req=111 held; each owner drops its req after 2 cycles -> grants 001, 010, 100 back-to-back with no idle cycle between them.
REQ-033 MAX_HOLD=8, req=011, lock=00, owner 0 never releases -> on cycle 8 of ownership grant=010 and preempt pulses once; owner 0 is regranted after owner 1 releases.
REQ-034 Same as REQ-033 but lock[0]=1 -> grant stays 001 for 20+ cycles; preempt stays 0.
REQ-035 Owner 0 drops req on the same edge hold_cnt reaches MAX_HOLD with req[1] high -> grant=010 and preempt=0.
REQ-036 Assert reset_cycle asynchronously mid-ownership with grant=100 -> grant, busy and owner are 0 before the next clock edge; after release, req=111 grants 001 first.
